mbf_chan_decimate_scale: RTL and testbench
==========================================

// Module: mbf_chan_decimate_scale
// PURPOSE
//  Multichannel decimate-and-scale stage: programmable factor D (1..DCEF_MAX), round/saturate IN_W->OUT_W.
//  Sits after the MBF FIR in each MHBF stage, replacing the fixed-D=2 decimator plus separate out-scale.
//  Per-channel phase counters, TDM-interleaved stream tagged by ChIdx.
//  Adds: runtime D and shift config, phase resync, decimation bypass.
// PARAMETERS
//  IN_W          54  input sample width (FIR accumulator), signed
//  OUT_W         24  output sample width, signed
//  NUM_CH        16  channels in use (1..2**CH_W)
//  CH_W          4   channel index width
//  DCEF_MAX      16  largest decimation factor
//  DCEF_DEFAULT  2   D after reset
//  SHIFT_DEFAULT 30  right-shift after reset
//  CFG_W         24  config word width
// PORTS
//  CLK             in   1      clock
//  RST             in   1      synchronous reset, active high
//  isConfig        in   1      config word valid; held high for the whole 2-word sequence
//  Data_Config_In  in   CFG_W  config word: word0 = D, word1 = shift
//  isConfigACK     out  1      1-cycle pulse after each accepted word
//  isConfigDone    out  1      1-cycle pulse when new settings commit
//  Phase_Sync      in   1      clear all phase counters
//  Bypass_Dec      in   1      1 = keep every sample (D treated as 1); scaling still applied
//  Data_In         in   IN_W   signed sample
//  Data_In_Valid   in   1      sample strobe
//  Data_In_ChIdx   in   CH_W   sample channel
//  Data_Out        out  OUT_W  signed scaled sample
//  Data_Out_Valid  out  1      output strobe
//  Data_Out_ChIdx  out  CH_W   output channel
// BEHAVIOUR
//  Reset
//  - all outputs 0; D=DCEF_DEFAULT; shift=SHIFT_DEFAULT; all cnt[ch]=0; config FSM in CFG_IDLE.
//  Datapath: 2-stage pipeline; sample at input edge n appears at edge n+2
//  - S0, on Data_In_Valid:
//    - keep = Bypass_Dec | (cnt[ch]==0)
//    - cnt[ch] <= (cnt[ch]+1 == D) ? 0 : cnt[ch]+1  (frozen when D==1)
//  - S1: r = (Data_In + (shift ? 1<<(shift-1) : 0)) >>> shift
//    - arithmetic at IN_W+1 bits; round half up.
//  - S2: saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//    - Data_Out_Valid = v1 & keep1; Data_Out/ChIdx registered.
//    - Data_Out/ChIdx hold their last value when valid is 0.
//  - Data_In_ChIdx >= NUM_CH: sample dropped; no counter update.
//  - Back-to-back valids on any channel mix are supported; no backpressure.
//  Phase_Sync
//  - clears all cnt before the S0 update that cycle.
//  - A valid sample in the same cycle sees cnt=0: it is kept and sets cnt[ch]=1 (0 if D==1).
//  Config FSM: CFG_IDLE -> CFG_SHIFT -> CFG_IDLE
//  - CFG_IDLE & isConfig: latch word0 as D_pend; ACK next cycle; go to CFG_SHIFT.
//  - CFG_SHIFT & isConfig: latch word1 as shift_pend; go to CFG_IDLE.
//    - Next cycle: ACK and Done together.
//    - D/shift commit at that same edge; all cnt cleared at that edge.
//  - CFG_SHIFT & !isConfig: abort to CFG_IDLE. No Done; active settings unchanged.
//  - Clamping at commit: D=0 -> 1; D>DCEF_MAX -> DCEF_MAX; shift>IN_W-1 -> IN_W-1.
//  - Samples already in S1/S2 at commit finish with their old keep flag and old shift.
//  - Samples entering S0 on the commit edge use the old settings.
//  Reset mid-operation
//  - Pipeline valids cleared; a pending config is discarded.
// TESTING
//  - Reset: assert RST 3 cycles with Data_In_Valid=1 -> all outputs 0; first output 2 cycles after release.
//  - D=2, 1 channel, inputs 0..7 each cycle, shift=0 -> outputs 0,2,4,6; latency 2 cycles.
//  - NUM_CH=4, D=3, round-robin ch0..3 x6 -> each channel outputs its samples 0 and 3, ChIdx correct.
//  - Config D=4, shift=4 -> ACK pulses 1 cycle after each word, Done with 2nd ACK.
//    - then input 0x18 -> 0x2 (round up); input -0x18 -> -0x1 (round half up).
//  - Saturation: shift=0, Data_In=2^40 -> 0x7FFFFF; Data_In=-2^40 -> 0x800000.
//  - Abort config after word0 -> no Done, D unchanged.
//  - Phase_Sync with valid on ch2, cnt[2]=1 -> that sample is output.
//  - Bypass_Dec=1 with D=4 -> every sample is output.

Source files
------------

// File: rtl/mbf_chan_decimate_scale.sv
// Multichannel decimate-and-scale stage.
// Per-channel phase counters pick which TDM samples to keep (factor D, or all in bypass).
// Kept samples are right-shifted with round-half-up, then saturated to OUT_W bits.
// A two-word config sequence (D, then shift) updates the settings at runtime.
module mbf_chan_decimate_scale #(
    parameter int unsigned IN_W          = 54,
    parameter int unsigned OUT_W         = 24,
    parameter int unsigned NUM_CH        = 16,
    parameter int unsigned CH_W          = 4,
    parameter int unsigned DCEF_MAX      = 16,
    parameter int unsigned DCEF_DEFAULT  = 2,
    parameter int unsigned SHIFT_DEFAULT = 30,
    parameter int unsigned CFG_W         = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             isConfig,
    input  logic [CFG_W-1:0] Data_Config_In,
    output logic             isConfigACK,
    output logic             isConfigDone,
    input  logic             Phase_Sync,
    input  logic             Bypass_Dec,
    input  logic [IN_W-1:0]  Data_In,
    input  logic             Data_In_Valid,
    input  logic [CH_W-1:0]  Data_In_ChIdx,
    output logic [OUT_W-1:0] Data_Out,
    output logic             Data_Out_Valid,
    output logic [CH_W-1:0]  Data_Out_ChIdx
);

    localparam int unsigned D_W       = $clog2(DCEF_MAX + 1);
    localparam int unsigned SH_W      = $clog2(IN_W);
    localparam int unsigned R_W       = IN_W + 1;
    localparam int unsigned NUM_SLOTS = 2 ** CH_W;

    localparam logic signed [R_W-1:0] SAT_MAX =
        {{(R_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [R_W-1:0] SAT_MIN =
        {{(R_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [0:0] {CfgIdle, CfgShift} cfg_state_t;

    // Config state and active settings
    cfg_state_t      cfg_state;
    logic [D_W-1:0]  dcef;
    logic [D_W-1:0]  d_pend;
    logic [SH_W-1:0] shift;
    logic            cfg_commit;
    logic [D_W-1:0]  d_clamped;
    logic [SH_W-1:0] sh_clamped;

    // Phase counters; slots at or above NUM_CH are never written
    logic [D_W-1:0]  cnt [NUM_SLOTS];
    logic            in_accept;
    logic            keep;
    logic [D_W-1:0]  cnt_cur;
    logic [D_W-1:0]  cnt_inc;
    logic [D_W-1:0]  cnt_next;

    // Pipeline registers
    logic                   s1_valid;
    logic [IN_W-1:0]        s1_data;
    logic [CH_W-1:0]        s1_ch;
    logic [SH_W-1:0]        s1_shift;
    logic signed [R_W-1:0]  s1_ext;
    logic signed [R_W-1:0]  s1_rnd;
    logic signed [R_W-1:0]  s1_r;
    logic                   s2_valid;
    logic signed [R_W-1:0]  s2_r;
    logic [CH_W-1:0]        s2_ch;
    logic [OUT_W-1:0]       s2_sat;

    // Clamp incoming config words to the legal ranges
    always_comb begin
        cfg_commit = (cfg_state == CfgShift) && isConfig;
        if (Data_Config_In == '0) begin
            d_clamped = D_W'(1);
        end else if (Data_Config_In > CFG_W'(DCEF_MAX)) begin
            d_clamped = D_W'(DCEF_MAX);
        end else begin
            d_clamped = Data_Config_In[D_W-1:0];
        end
        if (Data_Config_In > CFG_W'(IN_W - 1)) begin
            sh_clamped = SH_W'(IN_W - 1);
        end else begin
            sh_clamped = Data_Config_In[SH_W-1:0];
        end
    end

    // Config FSM: word0 = D, word1 = shift; both commit together on the second word
    always_ff @(posedge CLK) begin
        if (RST) begin
            cfg_state    <= CfgIdle;
            d_pend       <= D_W'(DCEF_DEFAULT);
            dcef         <= D_W'(DCEF_DEFAULT);
            shift        <= SH_W'(SHIFT_DEFAULT);
            isConfigACK  <= 1'b0;
            isConfigDone <= 1'b0;
        end else begin
            isConfigACK  <= 1'b0;
            isConfigDone <= 1'b0;
            case (cfg_state)
                CfgIdle: begin
                    if (isConfig) begin
                        d_pend      <= d_clamped;
                        isConfigACK <= 1'b1;
                        cfg_state   <= CfgShift;
                    end
                end
                CfgShift: begin
                    // Dropping isConfig here aborts without touching active settings
                    if (isConfig) begin
                        dcef         <= d_pend;
                        shift        <= sh_clamped;
                        isConfigACK  <= 1'b1;
                        isConfigDone <= 1'b1;
                    end
                    cfg_state <= CfgIdle;
                end
                default: cfg_state <= CfgIdle;
            endcase
        end
    end

    // S0 keep decision; Phase_Sync makes this cycle's sample see a zero phase
    always_comb begin
        in_accept = Data_In_Valid && (32'(Data_In_ChIdx) < NUM_CH);
        cnt_cur   = Phase_Sync ? '0 : cnt[Data_In_ChIdx];
        cnt_inc   = cnt_cur + D_W'(1);
        cnt_next  = (cnt_inc == dcef) ? '0 : cnt_inc;
        keep      = Bypass_Dec || (cnt_cur == '0);
    end

    // Phase counter update; a settings commit realigns every channel
    always_ff @(posedge CLK) begin
        if (RST || cfg_commit) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (Phase_Sync) begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    cnt[i] <= '0;
                end
            end
            if (in_accept) begin
                cnt[Data_In_ChIdx] <= cnt_next;
            end
        end
    end

    // S1 round-half-up shift and S2 saturation, evaluated one bit wider than the input
    always_comb begin
        s1_ext = {s1_data[IN_W-1], s1_data};
        s1_rnd = (s1_shift != '0) ? (R_W'(1) << (s1_shift - SH_W'(1))) : '0;
        s1_r   = (s1_ext + s1_rnd) >>> s1_shift;
        if (s2_r > SAT_MAX) begin
            s2_sat = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (s2_r < SAT_MIN) begin
            s2_sat = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            s2_sat = s2_r[OUT_W-1:0];
        end
    end

    // Pipeline; shift is captured at S0 so in-flight samples keep the settings they entered with
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid       <= 1'b0;
            s1_data        <= '0;
            s1_ch          <= '0;
            s1_shift       <= '0;
            s2_valid       <= 1'b0;
            s2_r           <= '0;
            s2_ch          <= '0;
            Data_Out_Valid <= 1'b0;
            Data_Out       <= '0;
            Data_Out_ChIdx <= '0;
        end else begin
            s1_valid       <= in_accept && keep;
            s1_data        <= Data_In;
            s1_ch          <= Data_In_ChIdx;
            s1_shift       <= shift;
            s2_valid       <= s1_valid;
            s2_r           <= s1_r;
            s2_ch          <= s1_ch;
            Data_Out_Valid <= s2_valid;
            if (s2_valid) begin
                Data_Out       <= s2_sat;
                Data_Out_ChIdx <= s2_ch;
            end
        end
    end

endmodule

// File: tb/tb_mbf_chan_decimate_scale.sv
// Directed bench for mbf_chan_decimate_scale (instantiated with NUM_CH=4).
module tb_mbf_chan_decimate_scale;

    logic        CLK = 1'b0;
    logic        RST;
    logic        isConfig;
    logic [23:0] Data_Config_In;
    logic        isConfigACK;
    logic        isConfigDone;
    logic        Phase_Sync;
    logic        Bypass_Dec;
    logic [53:0] Data_In;
    logic        Data_In_Valid;
    logic [3:0]  Data_In_ChIdx;
    logic [23:0] Data_Out;
    logic        Data_Out_Valid;
    logic [3:0]  Data_Out_ChIdx;

    int errors = 0;
    int checks = 0;

    longint      vin[$];
    int          vch[$];
    logic [23:0] vexp[$];

    mbf_chan_decimate_scale #(
        .NUM_CH (4)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .isConfig       (isConfig),
        .Data_Config_In (Data_Config_In),
        .isConfigACK    (isConfigACK),
        .isConfigDone   (isConfigDone),
        .Phase_Sync     (Phase_Sync),
        .Bypass_Dec     (Bypass_Dec),
        .Data_In        (Data_In),
        .Data_In_Valid  (Data_In_Valid),
        .Data_In_ChIdx  (Data_In_ChIdx),
        .Data_Out       (Data_Out),
        .Data_Out_Valid (Data_Out_Valid),
        .Data_Out_ChIdx (Data_Out_ChIdx)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [23:0] d, input int ch);
        chk({tag, ".valid"}, Data_Out_Valid, v);
        if (v) begin
            chk({tag, ".data"}, Data_Out, d);
            chk({tag, ".ch"}, Data_Out_ChIdx, ch);
        end
    endtask

    task automatic drive(input logic v, input longint d, input int ch);
        Data_In_Valid = v;
        Data_In       = d[53:0];
        Data_In_ChIdx = ch[3:0];
    endtask

    task automatic idle();
        drive(1'b0, 0, 0);
    endtask

    task automatic cfg(input int d, input int sh);
        idle();
        isConfig       = 1'b1;
        Data_Config_In = d[23:0];
        tick();
        chk("cfg.ack0", isConfigACK, 1);
        chk("cfg.done0", isConfigDone, 0);
        Data_Config_In = sh[23:0];
        tick();
        chk("cfg.ack1", isConfigACK, 1);
        chk("cfg.done1", isConfigDone, 1);
        isConfig       = 1'b0;
        Data_Config_In = '0;
        tick();
        chk("cfg.ack_end", isConfigACK, 0);
        chk("cfg.done_end", isConfigDone, 0);
    endtask

    // Streams vin/vch back to back; every sample is expected out two edges later
    task automatic stream_kept(input string tag);
        for (int i = 0; i < vin.size() + 2; i++) begin
            if (i < vin.size()) drive(1'b1, vin[i], vch[i]);
            else idle();
            tick();
            if (i >= 2) chk_out(tag, 1'b1, vexp[i-2], vch[i-2]);
            else chk_out(tag, 1'b0, 24'h0, 0);
        end
        idle();
        tick();
        chk_out(tag, 1'b0, 24'h0, 0);
    endtask

    initial begin
        RST = 1'b1;
        isConfig = 1'b0;
        Data_Config_In = '0;
        Phase_Sync = 1'b0;
        Bypass_Dec = 1'b0;
        drive(1'b1, longint'(5) << 30, 0);

        // Reset with valid held high
        repeat (3) tick();
        chk("rst.valid", Data_Out_Valid, 0);
        chk("rst.data", Data_Out, 0);
        chk("rst.ch", Data_Out_ChIdx, 0);
        chk("rst.ack", isConfigACK, 0);
        chk("rst.done", isConfigDone, 0);
        RST = 1'b0;
        tick();
        idle();
        chk("lat.e0", Data_Out_Valid, 0);
        tick();
        chk("lat.e1", Data_Out_Valid, 0);
        tick();
        chk_out("lat.e2", 1'b1, 24'd5, 0);   // default shift 30
        tick();
        chk("hold.valid", Data_Out_Valid, 0);
        chk("hold.data", Data_Out, 24'd5);

        // D=2, shift=0, ramp 0..7 on ch0 -> 0,2,4,6
        cfg(2, 0);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, i, 0);
            else idle();
            tick();
            if (i >= 2 && ((i - 2) % 2) == 0) chk_out("d2", 1'b1, 24'(i - 2), 0);
            else chk_out("d2", 1'b0, 24'h0, 0);
        end

        // D=3, round-robin ch0..3 x6; data = ch*16 + per-channel index
        cfg(3, 0);
        for (int j = 0; j < 26; j++) begin
            if (j < 24) drive(1'b1, (j % 4) * 16 + j / 4, j % 4);
            else idle();
            tick();
            if (j >= 2 && (((j - 2) / 4) % 3) == 0)
                chk_out("rr", 1'b1, 24'(((j - 2) % 4) * 16 + (j - 2) / 4), (j - 2) % 4);
            else chk_out("rr", 1'b0, 24'h0, 0);
        end

        // Out-of-range channel is dropped
        drive(1'b1, 99, 5);
        tick();
        idle();
        tick();
        tick();
        chk("drop.valid", Data_Out_Valid, 0);

        // D=4, shift=4: rounding on fresh channels
        cfg(4, 4);
        vin = '{longint'(24), -longint'(24), longint'(23)};
        vch = '{0, 1, 2};
        vexp = '{24'h000002, 24'hFFFFFF, 24'h000001};
        stream_kept("rnd");

        // D=1, shift=0: saturation
        cfg(1, 0);
        vin = '{longint'(1) << 40, -(longint'(1) << 40), (longint'(1) << 23) - 1,
                longint'(1) << 23, -(longint'(1) << 23), -(longint'(1) << 23) - 1,
                longint'(5)};
        vch = '{0, 0, 0, 0, 0, 0, 0};
        vexp = '{24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h7FFFFF, 24'h800000,
                 24'h800000, 24'h000005};
        stream_kept("sat");

        // Abort after word0: no Done, D stays 1
        isConfig = 1'b1;
        Data_Config_In = 24'd4;
        tick();
        chk("abort.ack0", isConfigACK, 1);
        isConfig = 1'b0;
        tick();
        chk("abort.ack1", isConfigACK, 0);
        chk("abort.done1", isConfigDone, 0);
        tick();
        chk("abort.done2", isConfigDone, 0);
        vin = '{longint'(7), longint'(8), longint'(9)};
        vch = '{0, 0, 0};
        vexp = '{24'd7, 24'd8, 24'd9};
        stream_kept("abort");

        // Clamping: D=0 -> 1, shift=60 -> 53
        cfg(0, 60);
        vin = '{longint'(1) << 52, -(longint'(1) << 53), (longint'(1) << 52) - 1};
        vch = '{1, 1, 1};
        vexp = '{24'h000001, 24'hFFFFFF, 24'h000000};
        stream_kept("clamp");

        // Phase_Sync with cnt[2]=1
        cfg(4, 0);
        drive(1'b1, 21, 2);
        tick();
        drive(1'b1, 22, 2);
        Phase_Sync = 1'b1;
        tick();
        Phase_Sync = 1'b0;
        chk_out("sync.e0", 1'b0, 24'h0, 0);
        drive(1'b1, 23, 2);
        tick();
        chk_out("sync.a", 1'b1, 24'd21, 2);
        idle();
        tick();
        chk_out("sync.b", 1'b1, 24'd22, 2);
        tick();
        chk("sync.c.valid", Data_Out_Valid, 0);
        chk("sync.c.hold", Data_Out, 24'd22);

        // Bypass with D=4
        Bypass_Dec = 1'b1;
        vin = '{longint'(11), longint'(12), longint'(13), longint'(14)};
        vch = '{3, 3, 3, 3};
        vexp = '{24'd11, 24'd12, 24'd13, 24'd14};
        stream_kept("byp");
        Bypass_Dec = 1'b0;

        // Reset mid-operation: in-flight sample and pending config discarded
        drive(1'b1, 77, 0);
        isConfig = 1'b1;
        Data_Config_In = 24'd3;
        tick();
        chk("mrst.ack", isConfigACK, 1);
        RST = 1'b1;
        isConfig = 1'b0;
        idle();
        tick();
        chk("mrst.valid", Data_Out_Valid, 0);
        chk("mrst.data", Data_Out, 0);
        chk("mrst.ack_clr", isConfigACK, 0);
        RST = 1'b0;
        isConfig = 1'b1;
        Data_Config_In = 24'd7;
        tick();
        chk("mrst.word0.ack", isConfigACK, 1);
        chk("mrst.word0.done", isConfigDone, 0);
        chk("mrst.valid2", Data_Out_Valid, 0);
        isConfig = 1'b0;
        tick();
        chk("mrst.abort.done", isConfigDone, 0);
        chk("mrst.valid3", Data_Out_Valid, 0);

        // Defaults restored: D=2, shift=30
        drive(1'b1, longint'(5) << 30, 1);
        tick();
        drive(1'b1, longint'(6) << 30, 1);
        tick();
        idle();
        chk("def.e1", Data_Out_Valid, 0);
        tick();
        chk_out("def.a", 1'b1, 24'd5, 1);
        tick();
        chk("def.b.valid", Data_Out_Valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
